// File: rtl/log2_pkg.sv
// Shared constants, state encoding and the saturating exp2 helper for the
// log-compressed byte path (log2 encode side and exp2 decode side).
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ARM     = 2'd2,
    DRAIN   = 2'd3
  } burst_state_t;

  localparam int BURST_DEPTH_DEF = 6;
  localparam int BYTE_W          = 8;

  // Returns {sat, y}: y = 1 << e for e below the byte width, all ones otherwise.
  function automatic logic [BYTE_W:0] exp2_sat(input logic [BYTE_W-1:0] e);
    logic [BYTE_W:0] r;
    if (int'(e) < BYTE_W)
      r = {1'b0, {{(BYTE_W-1){1'b0}}, 1'b1} << e};
    else
      r = {1'b1, {BYTE_W{1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/burst_buf.sv
// DEPTH x W burst buffer: one write port, one read port with registered data.
module burst_buf #(
  parameter int DEPTH = 6,
  parameter int W     = 8,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/exp2_burst.sv
// Captures a burst of exponents, then replays it as saturated 2**e once the
// input burst ends (decode side of the log-compressed byte path).
module exp2_burst
  import log2_pkg::*;
#(
  parameter int DEPTH = BURST_DEPTH_DEF,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         validx,
  output logic [W-1:0] y,
  output logic         ysat,
  output logic         validy,
  output logic         busy,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_CAPTURE = 2'(CAPTURE);
  localparam logic [1:0] S_ARM     = 2'(ARM);
  localparam logic [1:0] S_DRAIN   = 2'(DRAIN);

  logic [1:0]    state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  rd_data;
  logic [IW-1:0] wr_addr;
  logic          wr_en;
  logic          rd_en;
  logic          last_beat;
  logic [W:0]    f_out;

  // wr_ptr doubles as the beat count; rd_ptr runs one ahead of the beat on y
  // because the buffer read is registered.
  assign last_beat = (rd_ptr == wr_ptr);
  assign wr_en     = validx && ((state == S_IDLE) ||
                               ((state == S_CAPTURE) && (wr_ptr < PW'(DEPTH))));
  assign wr_addr   = (state == S_IDLE) ? '0 : wr_ptr[IW-1:0];
  assign rd_en     = (state == S_ARM) || ((state == S_DRAIN) && !last_beat);
  assign f_out     = exp2_sat(rd_data);
  assign busy      = (state == S_CAPTURE) || (state == S_DRAIN);

  burst_buf #(
    .DEPTH (DEPTH),
    .W     (W),
    .IW    (IW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (x),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[IW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      y      <= '0;
      ysat   <= 1'b0;
      validy <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      validy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (validx) begin
            wr_ptr <= PW'(1);
            rd_ptr <= '0;
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (validx) begin
            if (wr_ptr < PW'(DEPTH))
              wr_ptr <= wr_ptr + PW'(1);
            else
              ovf <= 1'b1;
          end else begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          rd_ptr <= PW'(1);
          state  <= S_DRAIN;
          if (validx)
            ovf <= 1'b1;
        end
        S_DRAIN: begin
          validy <= 1'b1;
          ysat   <= f_out[W];
          y      <= f_out[W-1:0];
          if (last_beat)
            state <= S_IDLE;
          else
            rd_ptr <= rd_ptr + PW'(1);
          if (validx)
            ovf <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp2_burst.sv
// Directed self-checking bench for exp2_burst (DEPTH=6, W=8).
module tb_exp2_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = 8'd0;
  logic       validx = 1'b0;
  logic [7:0] y;
  logic       ysat;
  logic       validy;
  logic       busy;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0] stim [$];
  logic [7:0] exp_y [$];
  logic       exp_s [$];
  logic [7:0] got_y [$];
  logic       got_s [$];
  int         lat;

  exp2_burst #(.DEPTH(6), .W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .validx (validx),
    .y      (y),
    .ysat   (ysat),
    .validy (validy),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    validx = 1'b0;
    x = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_burst();
    for (int i = 0; i < stim.size(); i++) begin
      x = stim[i];
      validx = 1'b1;
      tick();
    end
    validx = 1'b0;
    x = 8'd0;
  endtask

  // Waits (bounded) for the output burst and records every beat.
  task automatic collect();
    int waitc = 0;
    int beats = 0;
    got_y.delete();
    got_s.delete();
    lat = -1;
    while (!validy && waitc < 20) begin
      tick();
      waitc++;
    end
    if (validy) lat = waitc;
    while (validy && beats < 20) begin
      got_y.push_back(y);
      got_s.push_back(ysat);
      beats++;
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      checks += 5;
      if (y !== 8'd0)     begin errors++; $display("[TB] FAIL reset_y cycle %0d: got %0d want 0", c, y); end
      if (ysat !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ysat cycle %0d: got %b want 0", c, ysat); end
      if (validy !== 1'b0) begin errors++; $display("[TB] FAIL reset_validy cycle %0d: got %b want 0", c, validy); end
      if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy cycle %0d: got %b want 0", c, busy); end
      if (ovf !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ovf cycle %0d: got %b want 0", c, ovf); end
      tick();
    end
  endtask

  task automatic test_basic();
    stim = {8'd0, 8'd1, 8'd3, 8'd7};
    exp_y = {8'd1, 8'd2, 8'd8, 8'd128};
    send_burst();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_capture: got %b want 1", busy); end
    collect();
    checks += 3;
    if (lat != 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 3", lat); end
    if (got_y.size() != 4) begin errors++; $display("[TB] FAIL basic_beats: got %0d want 4", got_y.size()); end
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b want 0", ovf); end
    for (int i = 0; i < exp_y.size(); i++) begin
      checks += 2;
      if (i >= got_y.size() || got_y[i] !== exp_y[i]) begin errors++; $display("[TB] FAIL basic_y[%0d]: got %0d want %0d", i, (i < got_y.size()) ? got_y[i] : 8'd0, exp_y[i]); end
      if (i >= got_s.size() || got_s[i] !== 1'b0) begin errors++; $display("[TB] FAIL basic_ysat[%0d]: got %b want 0", i, (i < got_s.size()) ? got_s[i] : 1'b0); end
    end
  endtask

  task automatic test_saturate();
    stim = {8'd8, 8'd200};
    exp_y = {8'd255, 8'd255};
    exp_s = {1'b1, 1'b1};
    send_burst();
    collect();
    checks += 2;
    if (lat != 3) begin errors++; $display("[TB] FAIL sat_latency: got %0d want 3", lat); end
    if (got_y.size() != 2) begin errors++; $display("[TB] FAIL sat_beats: got %0d want 2", got_y.size()); end
    for (int i = 0; i < exp_y.size(); i++) begin
      checks += 2;
      if (i >= got_y.size() || got_y[i] !== exp_y[i]) begin errors++; $display("[TB] FAIL sat_y[%0d]: got %0d want %0d", i, (i < got_y.size()) ? got_y[i] : 8'd0, exp_y[i]); end
      if (i >= got_s.size() || got_s[i] !== exp_s[i]) begin errors++; $display("[TB] FAIL sat_ysat[%0d]: got %b want %b", i, (i < got_s.size()) ? got_s[i] : 1'b0, exp_s[i]); end
    end
  endtask

  task automatic test_full_depth();
    stim = {8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_y = {8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    send_burst();
    collect();
    checks += 2;
    if (got_y.size() != 6) begin errors++; $display("[TB] FAIL full_beats: got %0d want 6", got_y.size()); end
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL full_ovf: got %b want 0", ovf); end
    for (int i = 0; i < exp_y.size(); i++) begin
      checks++;
      if (i >= got_y.size() || got_y[i] !== exp_y[i]) begin errors++; $display("[TB] FAIL full_y[%0d]: got %0d want %0d", i, (i < got_y.size()) ? got_y[i] : 8'd0, exp_y[i]); end
    end
  endtask

  task automatic test_overflow();
    stim = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_y = {8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32};
    send_burst();
    collect();
    checks += 2;
    if (got_y.size() != 6) begin errors++; $display("[TB] FAIL ovf_beats: got %0d want 6", got_y.size()); end
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b want 1", ovf); end
    for (int i = 0; i < exp_y.size(); i++) begin
      checks++;
      if (i >= got_y.size() || got_y[i] !== exp_y[i]) begin errors++; $display("[TB] FAIL ovf_y[%0d]: got %0d want %0d", i, (i < got_y.size()) ? got_y[i] : 8'd0, exp_y[i]); end
    end
    tick();
    tick();
    tick();
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_drain_pulse();
    apply_reset();
    stim = {8'd1, 8'd2, 8'd3};
    exp_y = {8'd2, 8'd4, 8'd8};
    send_burst();
    got_y.delete();
    tick();
    tick();
    tick();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL pulse_ovf_before: got %b want 0", ovf); end
    if (validy) got_y.push_back(y);
    x = 8'd9;
    validx = 1'b1;
    tick();
    validx = 1'b0;
    x = 8'd0;
    if (validy) got_y.push_back(y);
    tick();
    if (validy) got_y.push_back(y);
    checks += 2;
    if (got_y.size() != 3) begin errors++; $display("[TB] FAIL pulse_beats: got %0d want 3", got_y.size()); end
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL pulse_ovf: got %b want 1", ovf); end
    for (int i = 0; i < exp_y.size(); i++) begin
      checks++;
      if (i >= got_y.size() || got_y[i] !== exp_y[i]) begin errors++; $display("[TB] FAIL pulse_y[%0d]: got %0d want %0d", i, (i < got_y.size()) ? got_y[i] : 8'd0, exp_y[i]); end
    end
    stim = {8'd4};
    send_burst();
    collect();
    checks += 3;
    if (lat != 3) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 3", lat); end
    if (got_y.size() != 1) begin errors++; $display("[TB] FAIL b2b_beats: got %0d want 1", got_y.size()); end
    if (got_y.size() < 1 || got_y[0] !== 8'd16) begin errors++; $display("[TB] FAIL b2b_y: got %0d want 16", (got_y.size() > 0) ? got_y[0] : 8'd0); end
  endtask

  task automatic test_reset_mid_drain();
    int extra = 0;
    apply_reset();
    stim = {8'd2, 8'd3, 8'd4, 8'd5};
    send_burst();
    tick();
    tick();
    tick();
    checks += 2;
    if (validy !== 1'b1) begin errors++; $display("[TB] FAIL mid_validy_pre: got %b want 1", validy); end
    if (y !== 8'd4) begin errors++; $display("[TB] FAIL mid_y_pre: got %0d want 4", y); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 2;
    if (validy !== 1'b0) begin errors++; $display("[TB] FAIL mid_validy_rst: got %b want 0", validy); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_rst: got %b want 0", busy); end
    for (int c = 0; c < 6; c++) begin
      if (validy) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL mid_extra_beats: got %0d want 0", extra); end
    stim = {8'd5};
    send_burst();
    collect();
    checks += 3;
    if (got_y.size() != 1) begin errors++; $display("[TB] FAIL single_beats: got %0d want 1", got_y.size()); end
    if (got_y.size() < 1 || got_y[0] !== 8'd32) begin errors++; $display("[TB] FAIL single_y: got %0d want 32", (got_y.size() > 0) ? got_y[0] : 8'd0); end
    if (got_s.size() < 1 || got_s[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_ysat: got %b want 0", (got_s.size() > 0) ? got_s[0] : 1'b1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_full_depth();
    test_overflow();
    test_drain_pulse();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
